knn_sequencer: RTL and testbench

Control sequencer for the `knnTop_regwrap` KNN datapath. It accepts a configuration command and a valid/ready stream of packed feature beats from the host side. It drives the datapath's `start` / `wr_en` / `done` / `rd_en` / `k` controls in the required order: one reference vector, N training vectors, a drain interval, then k result reads. Results come back to the host as a valid/ready stream. It sits between the AXI register/DMA front end and the datapath wrapper.

---
 rtl/knn_pkg.sv | 26 ++
 rtl/knn_beat_counter.sv | 45 ++++
 rtl/knn_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_knn_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared types and default constants for the KNN datapath sequencer.
package knn_pkg;

    localparam int KNN_DATA_WIDTH   = 32;
    localparam int KNN_NUM_DIMS     = 5;
    localparam int KNN_NUM_CHANNELS = 2;
    localparam int KNN_RD_LATENCY   = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_LOAD_REF,
        S_LOAD_TRAIN,
        S_DRAIN,
        S_READ_REQ,
        S_READ_WAIT,
        S_READ_HOLD,
        S_FINISH
    } knn_seq_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/knn_beat_counter.sv
// Dimension/vector counter pair; reused for the reference vector (limit 1)
// and for the training set (limit num_train).
module knn_beat_counter
    import knn_pkg::*;
#(
    parameter int NUM_DIMS  = KNN_NUM_DIMS,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic [CNT_WIDTH-1:0] i_vec_limit,
    output logic                 o_dim_last,
    output logic                 o_vec_last
);

    localparam int               DIM_W   = cnt_bits(NUM_DIMS);
    localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(NUM_DIMS - 1);

    logic [DIM_W-1:0]     r_dim;
    logic [CNT_WIDTH-1:0] r_vec;

    // Dimension counter wraps at NUM_DIMS and carries into the vector counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dim <= '0;
            r_vec <= '0;
        end else if (i_clr) begin
            r_dim <= '0;
            r_vec <= '0;
        end else if (i_en) begin
            if (o_dim_last) begin
                r_dim <= '0;
                r_vec <= r_vec + CNT_WIDTH'(1);
            end else begin
                r_dim <= r_dim + DIM_W'(1);
            end
        end
    end

    assign o_dim_last = (r_dim == DIM_MAX);
    assign o_vec_last = (r_vec == (i_vec_limit - CNT_WIDTH'(1)));

endmodule

// File: rtl/knn_sequencer.sv
// Control sequencer for the KNN datapath: reference load, training load,
// drain, then k result reads returned as a valid/ready stream.
//
// state       | meaning
// ------------+----------------------------------------------------
// IDLE        | waiting for cfg_start; rejects bad commands
// ARM         | knn_k settles one cycle before knn_start
// LOAD_REF    | NUM_DIMS beats of the reference vector
// LOAD_TRAIN  | num_train x NUM_DIMS beats of training vectors
// DRAIN       | DRAIN_CYCLES+1 idle cycles before knn_done
// READ_REQ    | one-cycle knn_rd_en
// READ_WAIT   | capture datapath result into the output register
// READ_HOLD   | hold result until consumer handshake
// FINISH      | drop start/done, pulse irq_done
module knn_sequencer
    import knn_pkg::*;
#(
    parameter int DATA_WIDTH   = KNN_DATA_WIDTH,
    parameter int NUM_DIMS     = KNN_NUM_DIMS,
    parameter int NUM_CHANNELS = KNN_NUM_CHANNELS,
    parameter int CNT_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cfg_start,
    input  logic [31:0]                        cfg_k,
    input  logic [CNT_WIDTH-1:0]               cfg_num_train,
    input  logic                               cfg_abort,
    output logic                               busy,
    output logic                               cfg_err,
    output logic                               irq_done,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_data,
    output logic                               knn_start,
    output logic                               knn_wr_en,
    output logic                               knn_done,
    output logic                               knn_rd_en,
    output logic [31:0]                        knn_k,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] knn_data_in,
    input  logic [DATA_WIDTH-1:0]              knn_name_in,
    input  logic [DATA_WIDTH-1:0]              knn_value_in,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATA_WIDTH-1:0]              m_name,
    output logic [DATA_WIDTH-1:0]              m_value
);

    localparam int               DRN_W    = cnt_bits(DRAIN_CYCLES + 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES);

    knn_seq_state_t r_state, w_next;

    logic [31:0]                        r_k;
    logic [CNT_WIDTH-1:0]               r_num_train;
    logic [31:0]                        r_res_cnt;
    logic [DRN_W-1:0]                   r_drain_cnt;
    logic                               r_wr_en;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_data;
    logic                               r_m_valid;
    logic [DATA_WIDTH-1:0]              r_m_name;
    logic [DATA_WIDTH-1:0]              r_m_value;
    logic                               r_cfg_err;

    logic                 w_hs;
    logic                 w_reject;
    logic                 w_accept;
    logic                 w_loading;
    logic                 w_dim_last;
    logic                 w_vec_last;
    logic                 w_beat_clr;
    logic                 w_phase_done;
    logic [CNT_WIDTH-1:0] w_vec_limit;
    logic                 w_m_hs;
    logic                 w_res_last;

    // A beat caught in the same cycle as an abort is deliberately dropped.
    assign w_hs         = s_valid && s_ready && !cfg_abort;
    assign w_reject     = (cfg_k == 32'd0) || (cfg_num_train == '0) ||
                          (cfg_k > 32'(cfg_num_train));
    assign w_accept     = (r_state == S_IDLE) && cfg_start && !w_reject;
    assign w_loading    = (r_state == S_LOAD_REF) || (r_state == S_LOAD_TRAIN);
    assign w_vec_limit  = (r_state == S_LOAD_REF) ? CNT_WIDTH'(1) : r_num_train;
    assign w_phase_done = w_hs && w_dim_last && w_vec_last;
    assign w_beat_clr   = cfg_abort || !w_loading || w_phase_done;
    assign w_m_hs       = r_m_valid && m_ready;
    assign w_res_last   = ((r_res_cnt + 32'd1) == r_k);

    knn_beat_counter #(
        .NUM_DIMS  (NUM_DIMS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_beat_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (w_beat_clr),
        .i_en        (w_hs),
        .i_vec_limit (w_vec_limit),
        .o_dim_last  (w_dim_last),
        .o_vec_last  (w_vec_last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; abort overrides every transition.
    always_comb begin
        w_next = r_state;
        if (cfg_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:       if (w_accept) w_next = S_ARM;
                S_ARM:        w_next = S_LOAD_REF;
                S_LOAD_REF:   if (w_phase_done) w_next = S_LOAD_TRAIN;
                S_LOAD_TRAIN: if (w_phase_done) w_next = S_DRAIN;
                S_DRAIN:      if (r_drain_cnt == '0) w_next = S_READ_REQ;
                S_READ_REQ:   w_next = S_READ_WAIT;
                S_READ_WAIT:  w_next = S_READ_HOLD;
                S_READ_HOLD:  if (w_m_hs) w_next = w_res_last ? S_FINISH : S_READ_REQ;
                S_FINISH:     w_next = S_IDLE;
                default:      w_next = S_IDLE;
            endcase
        end
    end

    // State-decoded control levels and strobes.
    always_comb begin
        busy      = (r_state != S_IDLE);
        s_ready   = 1'b0;
        knn_start = 1'b0;
        knn_done  = 1'b0;
        knn_rd_en = 1'b0;
        irq_done  = 1'b0;
        case (r_state)
            S_LOAD_REF, S_LOAD_TRAIN: begin
                s_ready   = 1'b1;
                knn_start = 1'b1;
            end
            S_DRAIN:     knn_start = 1'b1;
            S_READ_REQ: begin
                knn_start = 1'b1;
                knn_done  = 1'b1;
                knn_rd_en = 1'b1;
            end
            S_READ_WAIT, S_READ_HOLD: begin
                knn_start = 1'b1;
                knn_done  = 1'b1;
            end
            S_FINISH:    irq_done = 1'b1;
            default: ;
        endcase
    end

    // Command latch, write pipeline, drain timer and result counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k         <= '0;
            r_num_train <= '0;
            r_cfg_err   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_data      <= '0;
            r_drain_cnt <= '0;
            r_res_cnt   <= '0;
        end else if (cfg_abort) begin
            r_k         <= '0;
            r_num_train <= '0;
            r_cfg_err   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_data      <= '0;
            r_drain_cnt <= '0;
            r_res_cnt   <= '0;
        end else begin
            r_cfg_err <= (r_state == S_IDLE) && cfg_start && w_reject;
            if (w_accept) begin
                r_k         <= cfg_k;
                r_num_train <= cfg_num_train;
            end
            r_wr_en <= w_hs;
            if (w_hs) r_data <= s_data;
            if (r_state != S_DRAIN)    r_drain_cnt <= DRN_LOAD;
            else if (r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - DRN_W'(1);
            if (r_state == S_IDLE)                    r_res_cnt <= '0;
            else if (r_state == S_READ_HOLD && w_m_hs) r_res_cnt <= r_res_cnt + 32'd1;
        end
    end

    // Result output register; contents hold while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_valid <= 1'b0;
            r_m_name  <= '0;
            r_m_value <= '0;
        end else if (cfg_abort) begin
            r_m_valid <= 1'b0;
            r_m_name  <= '0;
            r_m_value <= '0;
        end else if (r_state == S_READ_WAIT) begin
            r_m_valid <= 1'b1;
            r_m_name  <= knn_name_in;
            r_m_value <= knn_value_in;
        end else if (w_m_hs) begin
            r_m_valid <= 1'b0;
        end
    end

    assign cfg_err     = r_cfg_err;
    assign knn_wr_en   = r_wr_en;
    assign knn_data_in = r_data;
    assign knn_k       = r_k;
    assign m_valid     = r_m_valid;
    assign m_name      = r_m_name;
    assign m_value     = r_m_value;

endmodule

// File: tb/tb_knn_sequencer.sv
// Directed bench for knn_sequencer with a 1-cycle-latency datapath responder.
module tb_knn_sequencer;

    localparam int DW = 32;
    localparam int ND = 5;
    localparam int NC = 2;
    localparam int CW = 16;
    localparam int DC = 10;
    localparam int BW = NC * DW;

    logic          clk;
    logic          reset;
    logic          cfg_start;
    logic [31:0]   cfg_k;
    logic [CW-1:0] cfg_num_train;
    logic          cfg_abort;
    logic          busy, cfg_err, irq_done;
    logic          s_valid, s_ready;
    logic [BW-1:0] s_data;
    logic          knn_start, knn_wr_en, knn_done, knn_rd_en;
    logic [31:0]   knn_k;
    logic [BW-1:0] knn_data_in;
    logic [DW-1:0] knn_name_in, knn_value_in;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_name, m_value;

    knn_sequencer #(
        .DATA_WIDTH(DW), .NUM_DIMS(ND), .NUM_CHANNELS(NC),
        .CNT_WIDTH(CW), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_k(cfg_k), .cfg_num_train(cfg_num_train),
        .cfg_abort(cfg_abort), .busy(busy), .cfg_err(cfg_err), .irq_done(irq_done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .knn_start(knn_start), .knn_wr_en(knn_wr_en), .knn_done(knn_done),
        .knn_rd_en(knn_rd_en), .knn_k(knn_k), .knn_data_in(knn_data_in),
        .knn_name_in(knn_name_in), .knn_value_in(knn_value_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_name(m_name), .m_value(m_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference {0,1},{0,2},{0,2},{0,2},{0,3}; training beats are arbitrary but distinct.
    function automatic logic [BW-1:0] beat_data(input int i);
        int ref_v [5] = '{1, 2, 2, 2, 3};
        if (i < ND) return {32'd0, 32'(ref_v[i])};
        return {32'(i), 32'(i * 3 + 1)};
    endfunction

    // Datapath responder: result appears one cycle after knn_rd_en.
    int rd_seq = 0;
    initial begin
        knn_name_in  = '0;
        knn_value_in = '0;
        forever begin
            @(negedge clk);
            if (knn_rd_en) begin
                knn_name_in  = 32'(32'hA0 + rd_seq);
                knn_value_in = 32'(32'h5000 + rd_seq * 7);
                rd_seq++;
            end
        end
    end

    // Cycle monitor: write pipeline, output holds, event counts.
    int            cyc = 0;
    int            n_wr = 0, n_rd = 0, n_mhs = 0, n_irq = 0;
    int            last_wr_cyc = 0, done_rise_cyc = 0;
    bit            prev_hs = 1'b0, prev_hold = 1'b0, prev_done = 1'b0, prev_rst = 1'b0;
    logic [BW-1:0] prev_data = '0;
    logic [DW-1:0] prev_name = '0, prev_value = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset && prev_rst) begin
            if (prev_hs || knn_wr_en) chk("wr_en_follows_hs", knn_wr_en, prev_hs);
            if (prev_hs) chk("wr_data", knn_data_in, prev_data);
            if (prev_hold) begin
                chk("m_valid_hold", m_valid, 1'b1);
                chk("m_name_hold", m_name, prev_name);
                chk("m_value_hold", m_value, prev_value);
                chk("no_rd_during_hold", knn_rd_en, 1'b0);
            end
        end
        if (knn_wr_en) begin
            n_wr++;
            last_wr_cyc = cyc;
        end
        if (knn_done && !prev_done) done_rise_cyc = cyc;
        if (knn_rd_en) n_rd++;
        if (m_valid && m_ready) n_mhs++;
        if (irq_done) n_irq++;
        prev_hs    = s_valid && s_ready && !cfg_abort;
        prev_data  = s_data;
        prev_hold  = m_valid && !m_ready;
        prev_name  = m_name;
        prev_value = m_value;
        prev_done  = knn_done;
        prev_rst   = reset;
    end

    task automatic chk_all_low(input string pfx);
        chk({pfx, "_busy"}, busy, 1'b0);
        chk({pfx, "_s_ready"}, s_ready, 1'b0);
        chk({pfx, "_knn_start"}, knn_start, 1'b0);
        chk({pfx, "_knn_wr_en"}, knn_wr_en, 1'b0);
        chk({pfx, "_knn_done"}, knn_done, 1'b0);
        chk({pfx, "_knn_rd_en"}, knn_rd_en, 1'b0);
        chk({pfx, "_knn_k"}, knn_k, 32'd0);
        chk({pfx, "_knn_data_in"}, knn_data_in, 64'd0);
        chk({pfx, "_m_valid"}, m_valid, 1'b0);
        chk({pfx, "_m_name"}, m_name, 32'd0);
        chk({pfx, "_m_value"}, m_value, 32'd0);
        chk({pfx, "_cfg_err"}, cfg_err, 1'b0);
        chk({pfx, "_irq_done"}, irq_done, 1'b0);
    endtask

    task automatic start_cmd(input int k, input int nt, input bit poke);
        cfg_k = 32'(k);
        cfg_num_train = CW'(nt);
        cfg_start = 1'b1;
        tick();
        chk("arm_busy", busy, 1'b1);
        chk("arm_knn_k", knn_k, 32'(k));
        chk("arm_knn_start_low", knn_start, 1'b0);
        chk("arm_s_ready_low", s_ready, 1'b0);
        if (poke) cfg_k = 32'd0;
        else      cfg_start = 1'b0;
        tick();
        cfg_start = 1'b0;
        chk("load_knn_start", knn_start, 1'b1);
        chk("load_s_ready", s_ready, 1'b1);
        chk("load_knn_k", knn_k, 32'(k));
        if (poke) chk("start_while_busy_no_err", cfg_err, 1'b0);
    endtask

    task automatic send_beats(input int n, input bit gaps, input int abort_at, output bit aborted);
        int i = 0;
        int budget = 300;
        bit tog = 1'b0;
        bit hs;
        aborted = 1'b0;
        while (i < n && budget > 0) begin
            budget--;
            s_data  = beat_data(i);
            s_valid = !(gaps && i >= ND && tog);
            tog     = !tog;
            hs      = s_valid && s_ready;
            if (hs && i == abort_at) begin
                cfg_abort = 1'b1;
                tick();
                cfg_abort = 1'b0;
                s_valid   = 1'b0;
                aborted   = 1'b1;
                break;
            end
            tick();
            if (hs) i++;
        end
        s_valid = 1'b0;
        if (!aborted) chk("beats_accepted", 64'(i), 64'(n));
    endtask

    task automatic read_results(input int k, input int base, input int bp_idx, input int rst_idx);
        for (int j = 0; j < k; j++) begin
            int budget = 60;
            while (!m_valid && budget > 0) begin
                tick();
                budget--;
            end
            chk("m_valid_seen", m_valid, 1'b1);
            chk("m_name", m_name, 32'(32'hA0 + base + j));
            chk("m_value", m_value, 32'(32'h5000 + (base + j) * 7));
            if (j == rst_idx) begin
                m_ready = 1'b0;
                tick();
                #2 reset = 1'b0;
                #1;
                chk_all_low("async_rst");
                @(posedge clk);
                #1 reset = 1'b1;
                m_ready = 1'b1;
                tick();
                chk("post_rst_busy", busy, 1'b0);
                chk("post_rst_m_valid", m_valid, 1'b0);
                return;
            end
            if (j == bp_idx) begin
                m_ready = 1'b0;
                repeat (5) tick();
                chk("bp_m_valid_still", m_valid, 1'b1);
                m_ready = 1'b1;
            end
            tick();
            chk("m_valid_cleared", m_valid, 1'b0);
        end
    endtask

    task automatic run_job(input int k, input int nt, input bit gaps, input int bp_idx,
                           input int abort_at, input int rst_idx, input bit poke);
        int w0 = n_wr;
        int r0 = n_rd;
        int h0 = n_mhs;
        int i0 = n_irq;
        int base = rd_seq;
        int budget = 20;
        bit ab;
        start_cmd(k, nt, poke);
        send_beats((nt + 1) * ND, gaps, abort_at, ab);
        if (ab) begin
            chk_all_low("abort");
            chk("abort_writes", 64'(n_wr - w0), 64'(abort_at));
            tick();
            chk("abort_idle_busy", busy, 1'b0);
            return;
        end
        read_results(k, base, bp_idx, rst_idx);
        if (rst_idx >= 0) return;
        while (!irq_done && budget > 0) begin
            tick();
            budget--;
        end
        chk("irq_done", irq_done, 1'b1);
        chk("finish_knn_start_low", knn_start, 1'b0);
        chk("finish_knn_done_low", knn_done, 1'b0);
        tick();
        chk("end_busy", busy, 1'b0);
        chk("end_irq_pulse", irq_done, 1'b0);
        chk("wr_count", 64'(n_wr - w0), 64'((nt + 1) * ND));
        chk("done_delay", 64'(done_rise_cyc - last_wr_cyc), 64'(DC + 1));
        chk("rd_count", 64'(n_rd - r0), 64'(k));
        chk("m_hs_count", 64'(n_mhs - h0), 64'(k));
        chk("irq_count", 64'(n_irq - i0), 64'd1);
    endtask

    task automatic reject_cmd(input string tag, input int k, input int nt);
        cfg_k = 32'(k);
        cfg_num_train = CW'(nt);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk({tag, "_cfg_err"}, cfg_err, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        tick();
        chk({tag, "_err_pulse"}, cfg_err, 1'b0);
        chk({tag, "_no_start"}, knn_start, 1'b0);
        chk({tag, "_knn_k"}, knn_k, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_k = '0;
        cfg_num_train = '0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_low("reset");
        reset = 1'b1;
        tick();
        tick();
        chk_all_low("idle");

        reject_cmd("rej_k0", 0, 3);
        reject_cmd("rej_k_gt_n", 4, 3);
        reject_cmd("rej_n0", 1, 0);

        run_job(3, 3, 1'b0, -1, -1, -1, 1'b1);   // nominal, with start poke while busy
        run_job(3, 3, 1'b1, 1, -1, -1, 1'b0);    // input gaps + backpressure on result 2
        run_job(3, 3, 1'b0, -1, 12, -1, 1'b0);   // abort on beat 12
        run_job(3, 3, 1'b0, -1, -1, -1, 1'b0);   // clean job after abort
        run_job(3, 3, 1'b0, -1, -1, 1, 1'b0);    // async reset in READ_HOLD
        run_job(2, 4, 1'b0, -1, -1, -1, 1'b0);   // clean job after reset, k < num_train

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
